wb_dma_xfer_seq: RTL
====================

// Module: wb_dma_xfer_seq
// PURPOSE
// Transfer sequencer feeding the DMA WISHBONE master interface (mast_* side). Accepts one memory-to-memory
// job (source, destination, word count) and moves it in chunks of up to BUF_DEPTH words: read a chunk into
// a local buffer, then write it out. It drives mast_go/mast_we/mast_wait/mast_adr/mast_din; it consumes
// mast_dout/mast_drdy/mast_err.
// PARAMETERS
// AW         32  address width (byte addresses, word aligned)
// DW         32  data width
// LEN_W      12  width of the word-count field
// BUF_DEPTH   4  chunk buffer depth in words; power of 2, >=2
// PORTS
// clk         in   1      clock
// rst         in   1      reset, asynchronous, active-high
// start       in   1      job request pulse; sampled only in IDLE
// src_adr     in   AW     source start address; bits [1:0] ignored, treated as 0
// dst_adr     in   AW     destination start address; bits [1:0] ignored, treated as 0
// len         in   LEN_W  number of words to move
// busy        out  1      job in progress
// done        out  1      one-cycle pulse: job completed
// err         out  1      one-cycle pulse: job aborted on mast_err
// words_left  out  LEN_W  words not yet written
// mast_go     out  1      request bus cycle
// mast_we     out  1      1 = write phase, 0 = read phase
// mast_wait   out  1      suppress the next strobe
// mast_adr    out  AW     current bus address
// mast_din    out  DW     write data: buffer head
// mast_dout   in   DW     read data from bus
// mast_drdy   in   1      word accepted/returned this cycle
// mast_err    in   1      bus error
// BEHAVIOUR
// - Reset: state=IDLE; busy, done, err, mast_go, mast_we, mast_wait = 0; mast_adr, mast_din, words_left = 0;
//   all pointers = 0; buffer contents undefined. Reset mid-job abandons the job silently (no done/err pulse).
// - FSM states: IDLE, READ, TURN, WRITE, FIN.
// - IDLE: on start with len!=0, latch src/dst ptrs ({adr[AW-1:2],2'b00}), words_left=len,
//   chunk=min(len,BUF_DEPTH). Next state READ; busy=1 from the next cycle.
//   start with len==0 -> FIN: done pulses 1 cycle later, no bus activity. start outside IDLE is ignored.
// - READ: mast_go=1, mast_we=0, mast_adr=src ptr. Each mast_drdy: buf[wp]<=mast_dout, wp++,
//   src ptr +=4. On the drdy of the chunk's last word: mast_wait=1 combinationally in that cycle;
//   next state TURN.
// - TURN: exactly one cycle, mast_go=0, mast_wait=1; mast_adr=dst ptr; next state WRITE.
// - WRITE: mast_go=1, mast_we=1, mast_adr=dst ptr, mast_din=buf[rp]. Each mast_drdy: rp++,
//   dst ptr +=4, words_left--. On the last word of the chunk: mast_wait=1 in that cycle.
//   If words_left reaches 0 -> FIN; else new chunk=min(words_left,BUF_DEPTH), one TURN cycle, then READ.
// - FIN: one cycle, done=1, busy=0 from the next cycle, go to IDLE.
// - Address arithmetic is modulo 2^AW: 0xFFFF_FFFC + 4 wraps to 0x0000_0000 without error.
// - mast_err in READ or WRITE (including the same cycle as mast_drdy, where err wins and the word is
//   not counted): mast_go=0 next cycle, err=1 for one cycle, busy=0, IDLE. words_left holds its value
//   until the next start.
// - mast_drdy/mast_err in IDLE, TURN or FIN are ignored.
// - Buffer pointers wrap at BUF_DEPTH. The buffer is always fully drained before the next read phase.
// CONFIGURATION
// WB_DMA_XFER_ADR_HOLD_EN defined: adds inputs src_hold, dst_hold (1 bit each, latched with start).
//   A held pointer does not increment (FIFO-port access); the other pointer is unaffected.
// Not defined: no such ports; both pointers always increment by 4.
// TESTING
// - len=3, src=0x100, dst=0x200, drdy every cycle -> reads 0x100,0x104,0x108; 1 TURN; writes 0x200..0x208
//   with the same data in order; done pulse; busy low after.
// - len=10, BUF_DEPTH=4 -> chunks 4,4,2; mast_go low for exactly one cycle at each phase change;
//   words_left steps 10->0.
// - len=0 -> done one cycle after FIN; mast_go never asserted.
// - len=6, mast_err on the 2nd write word -> err pulse; done never pulses; busy=0; words_left=5; a new start
//   runs normally.
// - src=0xFFFF_FFF8, len=3 -> read adr 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
// - rst asserted mid-WRITE -> all outputs to reset values immediately; start after release succeeds.
//   With ADR_HOLD_EN: src_hold=1 -> all reads at src.

Source files
------------

// File: rtl/wb_dma_xfer_seq_if.sv
// wb_dma_xfer_seq_if
//   Bundles the DMA WISHBONE master-side handshake used by wb_dma_xfer_seq.
//   master modport (sequencer side):
//     out mast_go    request bus cycle
//     out mast_we    1 = write phase, 0 = read phase
//     out mast_wait  suppress the next strobe
//     out mast_adr   current bus address (AW bits)
//     out mast_din   write data (DW bits)
//     in  mast_dout  read data (DW bits)
//     in  mast_drdy  word accepted/returned this cycle
//     in  mast_err   bus error
//   slave modport: the same signals with directions reversed.
interface wb_dma_xfer_seq_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          mast_go;
    logic          mast_we;
    logic          mast_wait;
    logic [AW-1:0] mast_adr;
    logic [DW-1:0] mast_din;
    logic [DW-1:0] mast_dout;
    logic          mast_drdy;
    logic          mast_err;

    modport master (
        output mast_go, mast_we, mast_wait, mast_adr, mast_din,
        input  mast_dout, mast_drdy, mast_err
    );

    modport slave (
        input  mast_go, mast_we, mast_wait, mast_adr, mast_din,
        output mast_dout, mast_drdy, mast_err
    );
endinterface

// File: rtl/wb_dma_xfer_seq.sv
// wb_dma_xfer_seq
//   Memory-to-memory transfer sequencer for the DMA WISHBONE master. One job
//   (source, destination, word count) is moved in chunks of up to BUF_DEPTH
//   words: a chunk is read into a local buffer, then written back out.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     start             job request pulse, sampled only in IDLE
//     src_adr, dst_adr  word-aligned start addresses (bits [1:0] ignored)
//     len               number of words to move
//     busy              job in progress
//     done / err        one-cycle completion / abort pulses
//     words_left        words not yet written
//     mast              master modport of wb_dma_xfer_seq_if
//   Optional feature macro: WB_DMA_XFER_ADR_HOLD_EN
//     adds src_hold / dst_hold inputs (latched with start); a held pointer
//     stays fixed for FIFO-port access.
module wb_dma_xfer_seq #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned LEN_W     = 12,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        src_adr,
    input  logic [AW-1:0]        dst_adr,
    input  logic [LEN_W-1:0]     len,
`ifdef WB_DMA_XFER_ADR_HOLD_EN
    input  logic                 src_hold,
    input  logic                 dst_hold,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [LEN_W-1:0]     words_left,
    wb_dma_xfer_seq_if.master    mast
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {IDLE, READ, TURN, WRITE, FIN} state_t;

    state_t          state;
    logic [AW-1:0]   src_ptr;
    logic [AW-1:0]   dst_ptr;
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [CW-1:0]   cnt;      // words remaining in the current phase
    logic [CW-1:0]   chunk;    // size of the current chunk
    logic            to_write; // direction of the pending TURN
    logic            go_q;
    logic            we_q;
    logic [DW-1:0]   mem [BUF_DEPTH];

    logic            rd_ack;
    logic            wr_ack;
    logic            last;
    logic            bus_err;
    logic [AW-1:0]   src_step;
    logic [AW-1:0]   dst_step;

`ifdef WB_DMA_XFER_ADR_HOLD_EN
    logic src_hold_q;
    logic dst_hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_hold_q <= 1'b0;
            dst_hold_q <= 1'b0;
        end else if (state == IDLE && start) begin
            src_hold_q <= src_hold;
            dst_hold_q <= dst_hold;
        end
    end

    assign src_step = src_hold_q ? '0 : AW'(4);
    assign dst_step = dst_hold_q ? '0 : AW'(4);
`else
    assign src_step = AW'(4);
    assign dst_step = AW'(4);
`endif

    function automatic logic [CW-1:0] min_chunk(input logic [LEN_W-1:0] n);
        if (n >= LEN_W'(BUF_DEPTH))
            return CW'(BUF_DEPTH);
        return n[CW-1:0];
    endfunction

    // An error in the same cycle as drdy wins: the word is not counted.
    assign bus_err = (state == READ || state == WRITE) && mast.mast_err;
    assign rd_ack  = (state == READ)  && mast.mast_drdy && !mast.mast_err;
    assign wr_ack  = (state == WRITE) && mast.mast_drdy && !mast.mast_err;
    assign last    = (cnt == CW'(1));

    assign mast.mast_go   = go_q;
    assign mast.mast_we   = we_q;
    assign mast.mast_wait = (state == TURN) || ((rd_ack || wr_ack) && last);
    assign mast.mast_adr  = (state == TURN || state == WRITE) ? dst_ptr : src_ptr;
    // Gated so the data bus reads as zero outside the write phase (and in reset).
    assign mast.mast_din  = (state == WRITE) ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (rd_ack)
            mem[wp] <= mast.mast_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            chunk      <= '0;
            to_write   <= 1'b0;
            go_q       <= 1'b0;
            we_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_left <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        words_left <= len;
                        busy       <= 1'b1;
                        if (len != '0) begin
                            src_ptr <= {src_adr[AW-1:2], 2'b00};
                            dst_ptr <= {dst_adr[AW-1:2], 2'b00};
                            wp      <= '0;
                            rp      <= '0;
                            cnt     <= min_chunk(len);
                            chunk   <= min_chunk(len);
                            go_q    <= 1'b1;
                            we_q    <= 1'b0;
                            state   <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end

                READ: begin
                    if (bus_err) begin
                        go_q  <= 1'b0;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (rd_ack) begin
                        wp      <= wp + PW'(1);
                        src_ptr <= src_ptr + src_step;
                        cnt     <= cnt - CW'(1);
                        if (last) begin
                            cnt      <= chunk;
                            go_q     <= 1'b0;
                            to_write <= 1'b1;
                            state    <= TURN;
                        end
                    end
                end

                TURN: begin
                    go_q  <= 1'b1;
                    we_q  <= to_write;
                    state <= to_write ? WRITE : READ;
                end

                WRITE: begin
                    if (bus_err) begin
                        go_q  <= 1'b0;
                        we_q  <= 1'b0;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (wr_ack) begin
                        rp         <= rp + PW'(1);
                        dst_ptr    <= dst_ptr + dst_step;
                        words_left <= words_left - LEN_W'(1);
                        cnt        <= cnt - CW'(1);
                        if (last) begin
                            go_q <= 1'b0;
                            we_q <= 1'b0;
                            // Chunks tile the job, so the final chunk ends at words_left==1.
                            if (words_left == LEN_W'(1)) begin
                                done  <= 1'b1;
                                state <= FIN;
                            end else begin
                                cnt      <= min_chunk(words_left - LEN_W'(1));
                                chunk    <= min_chunk(words_left - LEN_W'(1));
                                to_write <= 1'b0;
                                state    <= TURN;
                            end
                        end
                    end
                end

                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
